hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of consecutive IF/ID flush cycles per taken branch (legal 1..4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports IFID_rs1, IFID_rs2  input  5  source registers of the instruction in ID.
REQ-005 SHALL have ports IFID_use_rs1, IFID_use_rs2  input  1  the ID instruction actually reads rs1 / rs2.
REQ-006 SHALL have port IDEX_rd  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port IDEX_MemRead  input  1  the EX instruction is a load.
REQ-008 SHALL have port branch_taken  input  1  the EX stage resolved a taken branch or jump this cycle.
REQ-009 SHALL have port ex_busy  input  1  a multicycle EX operation is not yet complete.
REQ-010 SHALL have ports PC_write, IFID_write, IDEX_write  output  1  enable the PC and pipeline-register loads.
REQ-011 SHALL have ports IFID_flush, IDEX_flush, EXMEM_bubble  output  1  load a NOP or bubble into the named register.
REQ-012 SHALL have port state  output  2  FSM state: RUN=0, FLUSH=1, HOLD=2.

Function
REQ-013 SHALL implement the states RUN, FLUSH and HOLD, with a 2-bit flush counter (fcnt) and a return flag (ret_flush).
REQ-014 SHALL detect a load-use hazard as IDEX_MemRead & IDEX_rd!=0 & ((IDEX_rd==IFID_rs1 & IFID_use_rs1) | (IDEX_rd==IFID_rs2 & IFID_use_rs2)).
REQ-015 SHALL make all outputs combinational (Mealy) from the state and inputs, with zero-cycle latency; the default in RUN is PC_write=IFID_write=IDEX_write=1 and all flush/bubble outputs=0.
REQ-016 SHALL apply the priority ex_busy > branch_taken > load-use in every state.
REQ-017 SHALL, on ex_busy, drive PC_write=IFID_write=IDEX_write=0 and EXMEM_bubble=1; enter HOLD with ret_flush=(state==FLUSH); freeze fcnt.
REQ-018 SHALL, in HOLD with ex_busy low, drive the outputs of the return state for that cycle and move to FLUSH if ret_flush, else to RUN.
REQ-019 SHALL, on branch_taken (ex_busy low), drive PC_write=1, IFID_flush=1, IDEX_flush=1; if FLUSH_CYCLES>1, go to FLUSH with fcnt=FLUSH_CYCLES-1, else stay in RUN.
REQ-020 SHALL, in FLUSH with no event, drive PC_write=1, IFID_write=1, IFID_flush=1; decrement fcnt; go to RUN after the cycle in which fcnt==1.
REQ-021 SHALL restart fcnt at FLUSH_CYCLES-1 when branch_taken occurs in FLUSH.
REQ-022 SHALL ignore load-use in FLUSH, because the ID contents are discarded.
REQ-023 SHALL, on load-use in RUN, drive PC_write=0, IFID_write=0, IDEX_flush=1 for exactly that cycle, with no state change; the bubble clears the hazard on the next cycle.

Reset
REQ-024 SHALL, while reset is high, drive state=RUN, fcnt=0, ret_flush=0, PC_write=IFID_write=IDEX_write=0, and IFID_flush=IDEX_flush=EXMEM_bubble=1.
REQ-025 SHALL let reset override any state mid-operation, including HOLD and FLUSH, on the next rising edge.

Configuration
REQ-026 SHALL, with HAZARD_PERF_CNT_EN defined, add outputs stall_count and flush_count (32 bits each), which count load-use cycles and IFID_flush cycles respectively, wrap at 2^32, and clear on reset.
REQ-027 SHALL, without HAZARD_PERF_CNT_EN, omit both counter ports and their logic, leaving all other behaviour identical.

Structure
REQ-028 SHALL place the state encoding enum and the NOP constant 32'h00000013 in the shared package hazard_pkg.
REQ-029 SHALL be a single module with no sub-modules; the perf counters are inline under the macro.

Verification
REQ-030 SHALL cover: IDEX_MemRead=1, IDEX_rd=5, IFID_rs2=5, use_rs2=1 -> one cycle of PC_write=0, IFID_write=0, IDEX_flush=1, then normal operation; with IDEX_rd=0 -> no stall.
REQ-031 SHALL cover: branch_taken pulse with FLUSH_CYCLES=2 -> IFID_flush=1 for 2 cycles, IDEX_flush=1 in the first cycle only, state RUN->FLUSH->RUN.
REQ-032 SHALL cover: ex_busy held 3 cycles during FLUSH with fcnt=1 -> state=HOLD with EXMEM_bubble=1 for 3 cycles, then one FLUSH cycle, then RUN.
REQ-033 SHALL cover: simultaneous branch_taken and load-use -> flush outputs only, PC_write=1, stall_count unchanged.
REQ-034 SHALL cover: reset asserted while in HOLD -> next cycle state=RUN, all reset output values as in REQ-024, counters=0.
REQ-035 SHALL cover: with HAZARD_PERF_CNT_EN defined and stall_count preset via force to 32'hFFFFFFFF, one load-use cycle -> stall_count=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding and NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } hz_state_t;

    // addi x0, x0, 0 -- what a flushed pipeline register is loaded with
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multicycle-EX hold; optional perf counters (HAZARD_PERF_CNT_EN).
// Latency: all control outputs are combinational (Mealy) from state and inputs, zero cycles.
// Backpressure: ex_busy freezes PC and all pipeline registers and bubbles EX/MEM until it drops.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IFID_rs1,
    input  logic [4:0] IFID_rs2,
    input  logic       IFID_use_rs1,
    input  logic       IFID_use_rs2,
    input  logic [4:0] IDEX_rd,
    input  logic       IDEX_MemRead,
    input  logic       branch_taken,
    input  logic       ex_busy,
    output logic       PC_write,
    output logic       IFID_write,
    output logic       IDEX_write,
    output logic       IFID_flush,
    output logic       IDEX_flush,
    output logic       EXMEM_bubble,
    output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    localparam logic [1:0] FC_INIT = 2'(FLUSH_CYCLES - 1);

    hz_state_t  st_q, st_d, eff_st;
    logic [1:0] fcnt_q, fcnt_d;
    logic       ret_q, ret_d;
    logic       load_use;
    logic       stall_taken;

    assign state = st_q;

    always_comb begin
        load_use = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                   (((IDEX_rd == IFID_rs1) && IFID_use_rs1) ||
                    ((IDEX_rd == IFID_rs2) && IFID_use_rs2));

        // Leaving HOLD behaves exactly like the state we were frozen in
        eff_st = st_q;
        if (st_q == ST_HOLD && !ex_busy)
            eff_st = ret_q ? ST_FLUSH : ST_RUN;

        PC_write     = 1'b1;
        IFID_write   = 1'b1;
        IDEX_write   = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_flush   = 1'b0;
        EXMEM_bubble = 1'b0;
        st_d         = eff_st;
        fcnt_d       = fcnt_q;
        ret_d        = 1'b0;
        stall_taken  = 1'b0;

        if (ex_busy) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_bubble = 1'b1;
            st_d         = ST_HOLD;
            ret_d        = (st_q == ST_FLUSH) || (st_q == ST_HOLD && ret_q);
        end else if (branch_taken) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            fcnt_d     = FC_INIT;
            st_d       = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (eff_st == ST_FLUSH) begin
            // ID holds a wrong-path instruction, so load-use is irrelevant here
            IFID_flush = 1'b1;
            if (st_q == ST_FLUSH) begin
                if (fcnt_q <= 2'd1) begin
                    st_d   = ST_RUN;
                    fcnt_d = 2'd0;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                end
            end
        end else if (load_use) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_flush  = 1'b1;
            stall_taken = 1'b1;
        end

        if (reset) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            IFID_flush   = 1'b1;
            IDEX_flush   = 1'b1;
            EXMEM_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= ST_RUN;
            fcnt_q <= 2'd0;
            ret_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            fcnt_q <= fcnt_d;
            ret_q  <= ret_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_taken)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (IFID_flush)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=2); counter checks active when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
    logic       IFID_use_rs1, IFID_use_rs2, IDEX_MemRead, branch_taken, ex_busy;
    logic       PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, EXMEM_bubble;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count, flush_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .IFID_rs1     (IFID_rs1),
        .IFID_rs2     (IFID_rs2),
        .IFID_use_rs1 (IFID_use_rs1),
        .IFID_use_rs2 (IFID_use_rs2),
        .IDEX_rd      (IDEX_rd),
        .IDEX_MemRead (IDEX_MemRead),
        .branch_taken (branch_taken),
        .ex_busy      (ex_busy),
        .PC_write     (PC_write),
        .IFID_write   (IFID_write),
        .IDEX_write   (IDEX_write),
        .IFID_flush   (IFID_flush),
        .IDEX_flush   (IDEX_flush),
        .EXMEM_bubble (EXMEM_bubble),
        .state        (state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_count  (stall_count),
        .flush_count  (flush_count)
`endif
    );

    // {PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, EXMEM_bubble}
    logic [5:0] ov;
    assign ov = {PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, EXMEM_bubble};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input logic [5:0] v);
        check({tag, ".state"}, {30'd0, state}, {30'd0, st});
        check({tag, ".out"}, {26'd0, ov}, {26'd0, v});
    endtask

    // Apply one cycle of inputs at the falling edge, then settle before checking
    task automatic drive(input logic r, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic br, input logic busy);
        @(negedge clk);
        reset        = r;
        IDEX_MemRead = mr;
        IDEX_rd      = rd;
        IFID_rs1     = rs1;
        IFID_rs2     = rs2;
        IFID_use_rs1 = u1;
        IFID_use_rs2 = u2;
        branch_taken = br;
        ex_busy      = busy;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic branch();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic busy();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; IDEX_MemRead = 1'b0; IDEX_rd = 5'd0; IFID_rs1 = 5'd0; IFID_rs2 = 5'd0;
        IFID_use_rs1 = 1'b0; IFID_use_rs2 = 1'b0; branch_taken = 1'b0; ex_busy = 1'b0;

        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("rst", 2'd0, 6'b000111);
`ifdef HAZARD_PERF_CNT_EN
        check("rst.stall_cnt", stall_count, 32'd0);
        check("rst.flush_cnt", flush_count, 32'd0);
`endif

        idle();                 expect_out("idle", 2'd0, 6'b111000);

        // load-use on rs2, then the bubble clears it
        drive(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("lu", 2'd0, 6'b001010);
        drive(1'b0, 1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("lu_clr", 2'd0, 6'b111000);
        // x0 destination never stalls
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("lu_rd0", 2'd0, 6'b111000);

        // taken branch: two flush cycles, load-use in FLUSH ignored
        branch();               expect_out("br", 2'd0, 6'b111110);
        drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("br_f1", 2'd1, 6'b111100);
        idle();                 expect_out("br_run", 2'd0, 6'b111000);
`ifdef HAZARD_PERF_CNT_EN
        check("br.stall_cnt", stall_count, 32'd1);
        check("br.flush_cnt", flush_count, 32'd2);
`endif

        // ex_busy for 3 cycles while in FLUSH with fcnt=1
        branch();               expect_out("h_br", 2'd0, 6'b111110);
        busy();                 expect_out("h_b1", 2'd1, 6'b000001);
        busy();                 expect_out("h_b2", 2'd2, 6'b000001);
        busy();                 expect_out("h_b3", 2'd2, 6'b000001);
        idle();                 expect_out("h_exit", 2'd2, 6'b111100);
        idle();                 expect_out("h_fl", 2'd1, 6'b111100);
        idle();                 expect_out("h_run", 2'd0, 6'b111000);

        // branch wins over simultaneous load-use
        drive(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_out("bl", 2'd0, 6'b111110);
        idle();                 expect_out("bl_f", 2'd1, 6'b111100);
`ifdef HAZARD_PERF_CNT_EN
        check("bl.stall_cnt", stall_count, 32'd1);
`endif
        idle();                 expect_out("bl_run", 2'd0, 6'b111000);

        // branch inside FLUSH restarts the flush window
        branch();               expect_out("rs_br", 2'd0, 6'b111110);
        branch();               expect_out("rs_br2", 2'd1, 6'b111110);
        idle();                 expect_out("rs_f", 2'd1, 6'b111100);
        idle();                 expect_out("rs_run", 2'd0, 6'b111000);

        // HOLD entered from RUN returns to RUN
        busy();                 expect_out("hr_b", 2'd0, 6'b000001);
        idle();                 expect_out("hr_exit", 2'd2, 6'b111000);
        idle();                 expect_out("hr_run", 2'd0, 6'b111000);

        // reset while in HOLD
        busy();                 expect_out("r_b1", 2'd0, 6'b000001);
        busy();                 expect_out("r_b2", 2'd2, 6'b000001);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("r_rst", 2'd2, 6'b000111);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("r_rst2", 2'd0, 6'b000111);
`ifdef HAZARD_PERF_CNT_EN
        check("r.stall_cnt", stall_count, 32'd0);
        check("r.flush_cnt", flush_count, 32'd0);
`endif
        idle();                 expect_out("r_run", 2'd0, 6'b111000);

`ifdef HAZARD_PERF_CNT_EN
        // stall counter wraps at 2^32
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        drive(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("w_lu", 2'd0, 6'b001010);
        idle();
        check("w.stall_cnt", stall_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
